// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a note ROM and drives the tone generator with beat-timed notes.
// Build option: define MELODY_SEQ_LOOP_EN to replay the song from entry 0 until stop.
module melody_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 500_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [13:0]       rom_data,
    output logic [9:0]        note_code,
    output logic              note_valid,
    output logic              busy,
    output logic              done
);

    localparam int CYC_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CYC_W-1:0]  CYC_RELOAD = CYC_W'(BEAT_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_DONE
    } state_t;

`ifdef MELODY_SEQ_LOOP_EN
    localparam state_t END_STATE = S_FETCH;
    localparam bit     LOOP      = 1'b1;
`else
    localparam state_t END_STATE = S_DONE;
    localparam bit     LOOP      = 1'b0;
`endif

    state_t            state, state_d;
    logic [3:0]        beats, beats_d;
    logic [CYC_W-1:0]  cyc, cyc_d;
    logic [GAP_W-1:0]  gap, gap_d;
    logic [ADDR_W-1:0] rom_addr_d;
    logic [9:0]        note_code_d;
    logic              note_valid_d, busy_d, done_d;

    logic [3:0] rom_dur;
    logic [9:0] rom_note;
    assign rom_dur  = rom_data[13:10];
    assign rom_note = rom_data[9:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: state_d = start ? S_FETCH : S_IDLE;
                S_FETCH:        state_d = S_LOAD;
                S_LOAD:         state_d = (rom_dur == 4'd0) ? END_STATE : S_PLAY;
                S_PLAY:         if (cyc == '0 && beats == 4'd1) state_d = S_GAP;
                S_GAP:          if (gap == '0) state_d = (rom_addr == LAST_ADDR) ? END_STATE : S_FETCH;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    // Next values for the registered outputs and the beat/gap counters
    always_comb begin
        rom_addr_d   = rom_addr;
        note_code_d  = note_code;
        note_valid_d = note_valid;
        done_d       = 1'b0;
        beats_d      = beats;
        cyc_d        = cyc;
        gap_d        = gap;
        if (stop) begin
            rom_addr_d   = '0;
            note_code_d  = '0;
            note_valid_d = 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) rom_addr_d = '0;
                S_LOAD: begin
                    if (rom_dur == 4'd0) begin
                        done_d       = 1'b1;
                        note_code_d  = '0;
                        note_valid_d = 1'b0;
                        if (LOOP) rom_addr_d = '0;
                    end else begin
                        note_code_d  = rom_note;
                        note_valid_d = (rom_note != 10'd0);
                        beats_d      = rom_dur;
                        cyc_d        = CYC_RELOAD;
                    end
                end
                S_PLAY: begin
                    if (cyc != '0) begin
                        cyc_d = cyc - CYC_W'(1);
                    end else if (beats == 4'd1) begin
                        note_code_d  = '0;
                        note_valid_d = 1'b0;
                        gap_d        = GAP_RELOAD;
                    end else begin
                        beats_d = beats - 4'd1;
                        cyc_d   = CYC_RELOAD;
                    end
                end
                S_GAP: begin
                    if (gap != '0) begin
                        gap_d = gap - GAP_W'(1);
                    end else if (rom_addr == LAST_ADDR) begin
                        done_d = 1'b1;
                        if (LOOP) rom_addr_d = '0;
                    end else begin
                        rom_addr_d = rom_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d == S_FETCH) || (state_d == S_LOAD) ||
                 (state_d == S_PLAY)  || (state_d == S_GAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr   <= '0;
            note_code  <= '0;
            note_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            beats      <= '0;
            cyc        <= '0;
            gap        <= '0;
        end else begin
            rom_addr   <= rom_addr_d;
            note_code  <= note_code_d;
            note_valid <= note_valid_d;
            busy       <= busy_d;
            done       <= done_d;
            beats      <= beats_d;
            cyc        <= cyc_d;
            gap        <= gap_d;
        end
    end

endmodule
